data_mem_banked: RTL and testbench

//  Parametrised synchronous data memory for the pipelined CPU datapath, replacing the fixed 64x16 store.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 91 +++++++++
 rtl/data_mem_banked.sv | 137 +++++++++++++
 tb/tb_data_mem_banked.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory.
// Optional feature macro: DMEM_PARITY_EN (per-byte-lane even parity).
package dmem_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned BE_W       = DATA_W_DEF / 8;

    // Even parity bit for one byte lane: bit that makes the total count of ones even
    function automatic logic lane_parity(input logic [7:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage for the banked data memory: byte-lane writes and a registered read port.
// With DMEM_PARITY_EN defined, one even-parity bit per lane is stored and checked on read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef DMEM_PARITY_EN
    input  logic                  pinj_i,
    output logic                  perr_o,
`endif
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   wbe_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic                  rzero_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only on an accepted read, so it holds during backpressure
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par_q [DEPTH];
    logic [LANES-1:0] rpar_q;
    logic             perr_c;

    // Parity store: written alongside each enabled lane, optionally inverted for fault injection
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe_i[i]) begin
                    par_q[waddr_i][i] <= lane_parity(wdata_i[i*8 +: 8]) ^ pinj_i;
                end
            end
        end
    end

    // Parity read register tracks the data read register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpar_q <= '0;
        end else if (re_i) begin
            rpar_q <= rzero_i ? '0 : par_q[raddr_i];
        end
    end

    // Any lane whose stored parity disagrees with its data flags an error
    always_comb begin
        perr_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_parity(rdata_q[i*8 +: 8]) != rpar_q[i]) begin
                perr_c = 1'b1;
            end
        end
    end

    assign perr_o = perr_c;
`endif

endmodule

// File: rtl/data_mem_banked.sv
// Parametrised synchronous data memory with valid/ready request port, byte-lane writes,
// 1-cycle registered read response with backpressure, and a self-clearing init sequencer.
// Optional feature macro: DMEM_PARITY_EN adds per-lane parity plus rsp_perr / req_perr_inj.
module data_mem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 64,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  mem_clk,
    input  logic                  reset,
`ifdef DMEM_PARITY_EN
    input  logic                  req_perr_inj,
    output logic                  rsp_perr,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_W + 1;
    localparam logic [AW1-1:0]   DEPTH_A  = AW1'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   init_addr_q;
    logic [IDX_W-1:0]   init_addr_d;
    logic               init_busy_q;
    logic               rsp_valid_q;

    logic               req_ready_c;
    logic               oor_c;
    logic               rd_acc_c;
    logic               wr_acc_c;

    logic               arr_we_c;
    logic [DATA_W/8-1:0] arr_wbe_c;
    logic [IDX_W-1:0]   arr_waddr_c;
    logic [DATA_W-1:0]  arr_wdata_c;
    logic [DATA_W-1:0]  arr_rdata;

    // Handshake decode: accept only in RUN when the response slot is free or draining
    assign req_ready_c = ~reset & (state_q == ST_RUN) & (~rsp_valid_q | rsp_ready);
    assign oor_c       = {1'b0, req_addr} >= DEPTH_A;
    assign rd_acc_c    = req_valid & req_ready_c & ~req_we;
    assign wr_acc_c    = req_valid & req_ready_c & req_we & ~oor_c;
    assign init_addr_d = init_addr_q + IDX_W'(1);

    // Write port mux: init sequencer owns the array until RUN
    always_comb begin
        arr_we_c    = 1'b0;
        arr_wbe_c   = '0;
        arr_waddr_c = init_addr_q;
        arr_wdata_c = INIT_VAL;
        if (state_q == ST_INIT) begin
            arr_we_c  = 1'b1;
            arr_wbe_c = '1;
        end else if (wr_acc_c) begin
            arr_we_c    = 1'b1;
            arr_wbe_c   = req_be;
            arr_waddr_c = IDX_W'(req_addr);
            arr_wdata_c = req_wdata;
        end
    end

    // Control FSM: INIT sweeps every word once, RUN tracks the response slot
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_busy_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_addr_q <= init_addr_d;
                    if (init_addr_q == LAST_IDX) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_acc_c) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef DMEM_PARITY_EN
    logic arr_perr;
`endif

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (mem_clk),
        .rst_i   (reset),
`ifdef DMEM_PARITY_EN
        .pinj_i  (wr_acc_c & req_perr_inj),
        .perr_o  (arr_perr),
`endif
        .we_i    (arr_we_c),
        .wbe_i   (arr_wbe_c),
        .waddr_i (arr_waddr_c),
        .wdata_i (arr_wdata_c),
        .re_i    (rd_acc_c),
        .rzero_i (oor_c),
        .raddr_i (IDX_W'(req_addr)),
        .rdata_o (arr_rdata)
    );

    assign req_ready = req_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = arr_rdata;
    assign init_busy = init_busy_q;
`ifdef DMEM_PARITY_EN
    assign rsp_perr  = rsp_valid_q & arr_perr;
`endif

endmodule

// File: tb/tb_data_mem_banked.sv
// Self-checking bench for data_mem_banked: directed scenarios plus randomized traffic
// checked against a word-array / response-queue reference model.
module tb_data_mem_banked;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam logic [15:0] INIT_VAL = 16'h0000;

    logic        mem_clk   = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [1:0]  req_be    = 2'b00;
    logic [7:0]  req_addr  = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        init_busy;
`ifdef DMEM_PARITY_EN
    logic        req_perr_inj = 1'b0;
    logic        rsp_perr;
`endif

    data_mem_banked #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .mem_clk      (mem_clk),
        .reset        (reset),
`ifdef DMEM_PARITY_EN
        .req_perr_inj (req_perr_inj),
        .rsp_perr     (rsp_perr),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_be       (req_be),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .init_busy    (init_busy)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct packed {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    logic [15:0] ref_mem [DEPTH];
    logic [1:0]  ref_bad [DEPTH];
    exp_t        exp_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = INIT_VAL;
            ref_bad[i] = 2'b00;
        end
        exp_q.delete();
    endtask

    // One clock cycle: drive a request, check outputs, then advance the model past the next edge
    task automatic step(input logic v, input logic we, input logic [1:0] be, input logic [7:0] addr,
                        input logic [15:0] wd, input logic rdy, input logic inj);
        logic exp_rdy;
        int   a;
        exp_t e;
        @(negedge mem_clk);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = rdy;
`ifdef DMEM_PARITY_EN
        req_perr_inj = inj;
`endif
        #1;
        exp_rdy = (exp_q.size() == 0) || rdy;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        check_eq("init_busy", 32'(init_busy), 32'd0);
        if (exp_q.size() != 0) begin
            check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
`ifdef DMEM_PARITY_EN
            check_eq("rsp_perr", 32'(rsp_perr), 32'(exp_q[0].perr));
`endif
        end
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
        end
        if (v && exp_rdy) begin
            a = int'(addr);
            if (we) begin
                if (a < DEPTH) begin
                    for (int i = 0; i < 2; i++) begin
                        if (be[i]) begin
                            ref_mem[a][i*8 +: 8] = wd[i*8 +: 8];
                            ref_bad[a][i]        = inj;
                        end
                    end
                end
            end else begin
                e.data = (a < DEPTH) ? ref_mem[a] : 16'h0000;
                e.perr = (a < DEPTH) ? (|ref_bad[a]) : 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Reset for one edge, check reset outputs, then count the init sweep while poking requests
    task automatic do_reset();
        int cnt;
        @(negedge mem_clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge mem_clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_init_busy", 32'(init_busy), 32'd1);
        reset = 1'b0;
        model_init();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 2'b11;
        req_addr  = 8'd0;
        req_wdata = 16'hFFFF;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 5) begin
                check_eq("init_req_ready", 32'(req_ready), 32'd0);
            end
            @(negedge mem_clk);
            #1;
        end
        req_valid = 1'b0;
        check_eq("init_cycles", 32'(cnt), 32'd64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_init();
        do_reset();

        // Reads after init return INIT_VAL; word 0 ignored the write held during init
        step(1, 0, 2'b00, 8'd0,  16'h0, 1, 0);
        step(1, 0, 2'b00, 8'd31, 16'h0, 1, 0);
        step(1, 0, 2'b00, 8'd63, 16'h0, 1, 0);
        step(0, 0, 2'b00, 8'd0,  16'h0, 1, 0);

        // Byte-lane merge
        step(1, 1, 2'b11, 8'd5, 16'hA55A, 1, 0);
        step(1, 1, 2'b10, 8'd5, 16'h1200, 1, 0);
        step(1, 0, 2'b00, 8'd5, 16'h0,    1, 0);
        step(0, 0, 2'b00, 8'd0, 16'h0,    1, 0);
        check_eq("merge_model", 32'(ref_mem[5]), 32'h125A);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 2'b11, 8'(10 + i), 16'(16'h3C00 + i * 16'h0111), 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 2'b00, 8'(10 + i), 16'h0, 1, 0);
        end
        step(0, 0, 2'b00, 8'd0, 16'h0, 1, 0);

        // Backpressure for 3 cycles, then release with a new read on the same edge
        step(1, 0, 2'b00, 8'd5,  16'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'b00, 8'd12, 16'h0, 0, 0);
        end
        step(1, 0, 2'b00, 8'd12, 16'h0, 1, 0);
        step(0, 0, 2'b00, 8'd0,  16'h0, 1, 0);

        // Out-of-range write dropped, read returns 0, neighbour untouched
        step(1, 1, 2'b11, 8'd70, 16'hFFFF, 1, 0);
        step(1, 0, 2'b00, 8'd70, 16'h0,    1, 0);
        step(1, 0, 2'b00, 8'd6,  16'h0,    1, 0);
        step(0, 0, 2'b00, 8'd0,  16'h0,    1, 0);

`ifdef DMEM_PARITY_EN
        // Injected parity error surfaces on read-back
        step(1, 1, 2'b11, 8'd3, 16'h5A5A, 1, 1);
        step(1, 0, 2'b00, 8'd3, 16'h0,    1, 0);
        step(0, 0, 2'b00, 8'd0, 16'h0,    1, 0);
        check_eq("perr_model", 32'(|ref_bad[3]), 32'd1);
`endif

        // Randomized traffic with occasional out-of-range addresses and stalls
        for (int n = 0; n < 400; n++) begin
            logic inj;
            inj = 1'b0;
`ifdef DMEM_PARITY_EN
            inj = ($urandom % 8) == 0;
`endif
            step(($urandom % 4) != 0, 1'($urandom % 2), 2'($urandom % 4),
                 8'($urandom_range(0, 79)), 16'($urandom), ($urandom % 4) != 0, inj);
        end
        step(0, 0, 2'b00, 8'd0, 16'h0, 1, 0);
        step(0, 0, 2'b00, 8'd0, 16'h0, 1, 0);

        // Reset while a response is stalled
        step(1, 0, 2'b00, 8'd7, 16'h0, 1, 0);
        step(0, 0, 2'b00, 8'd0, 16'h0, 0, 0);
        do_reset();
        step(1, 0, 2'b00, 8'd5, 16'h0, 1, 0);
        step(0, 0, 2'b00, 8'd0, 16'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
